// File: rtl/sparse_extract_ctrl_pkg.sv
// Shared KeyGen constants, FSM state encoding and derived masks for sparse extraction.
// Used by the extraction controller, its BRAM interface and the priority encoder.
package keygen_pkg;

    localparam int R         = 10163;
    localparam int G_DAT_DEP = 159;
    localparam int G_ADDR_W  = 8;
    localparam int G_DAT_W   = 64;
    localparam int OFFSET_W  = 6;
    localparam int H_ADDR_W  = 7;
    localparam int H_DAT_W   = G_ADDR_W + OFFSET_W;
    localparam int H_DAT_DEP = 67;

    localparam int LAST_WORD_BITS = R - (G_DAT_DEP - 1) * G_DAT_W;

    localparam logic [G_ADDR_W-1:0] LAST_ADDR = G_ADDR_W'(G_DAT_DEP - 1);
    localparam logic [H_ADDR_W-1:0] H_FULL    = H_ADDR_W'(H_DAT_DEP);

    // Bits of the last f word that lie beyond x^(r-1) are padding and must never be reported.
    localparam logic [G_DAT_W-1:0] LAST_WORD_MASK =
        {G_DAT_W{1'b1}} >> (G_DAT_W - LAST_WORD_BITS);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_SCAN = 3'd2,
        ST_CLR  = 3'd3,
        ST_NEXT = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

endpackage

// File: rtl/sparse_extract_ctrl_if.sv
// BRAM-side port bundle of the sparse extractor: f (dense, read/clear) and h (sparse, write).
// master = controller side, slave = memory side.
interface sparse_extract_ctrl_if;
    import keygen_pkg::*;

    logic [G_ADDR_W-1:0] f_addra;
    logic                f_wea;
    logic [G_DAT_W-1:0]  f_douta;
    logic [G_DAT_W-1:0]  f_dina;
    logic [H_ADDR_W-1:0] h_addra;
    logic                h_wea;
    logic [H_DAT_W-1:0]  h_douta;

    modport master (
        output f_addra, f_wea, f_douta, h_addra, h_wea, h_douta,
        input  f_dina
    );

    modport slave (
        input  f_addra, f_wea, f_douta, h_addra, h_wea, h_douta,
        output f_dina
    );

endinterface

// File: rtl/sparse_extract_ctrl_lsb_prio_enc64.sv
// Combinational priority encoder: index of the lowest set bit of a 64-bit word.
// valid is low when the word is zero (idx is then 0).
module lsb_prio_enc64 (
    input  logic [63:0] din,
    output logic [5:0]  idx,
    output logic        valid
);

    // Descending scan so the last hit, i.e. the lowest set bit, wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (din[i]) begin
                idx   = 6'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sparse_extract_ctrl.sv
// Dense-to-sparse converter: scans f word by word, writes each set-bit position to h in order.
// Optional build macro SPARSE_EXTRACT_CLEAR_EN zeroes every fully scanned f word.
module sparse_extract_ctrl
    import keygen_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  done,
    output logic                  err,
    output logic [H_ADDR_W-1:0]   weight,
    output state_t                fsm_state,
    sparse_extract_ctrl_if.master mem
);

    // Control handshake: start is a one-cycle request accepted only in IDLE; each accepted
    // start produces exactly one done pulse unless reset intervenes. err/weight hold until next start.

    state_t              state, state_d;
    logic [1:0]          cnt, cnt_d;
    logic [G_DAT_W-1:0]  word, word_d;
    logic [G_ADDR_W-1:0] f_addra_q, f_addra_d;
    logic [H_ADDR_W-1:0] h_addra_q, h_addra_d;
    logic [H_DAT_W-1:0]  h_douta_q, h_douta_d;
    logic                h_wea_q, h_wea_d;
    logic [H_ADDR_W-1:0] weight_q, weight_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic [OFFSET_W-1:0] enc_idx;
    logic                enc_valid;

    lsb_prio_enc64 u_enc (
        .din   (word),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            word      <= '0;
            f_addra_q <= '0;
            h_addra_q <= '0;
            h_douta_q <= '0;
            h_wea_q   <= 1'b0;
            weight_q  <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            word      <= word_d;
            f_addra_q <= f_addra_d;
            h_addra_q <= h_addra_d;
            h_douta_q <= h_douta_d;
            h_wea_q   <= h_wea_d;
            weight_q  <= weight_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        word_d    = word;
        f_addra_d = f_addra_q;
        h_addra_d = h_addra_q;
        h_douta_d = h_douta_q;
        h_wea_d   = 1'b0;
        weight_d  = weight_q;
        err_d     = err_q;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    err_d     = 1'b0;
                    weight_d  = '0;
                    f_addra_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_RD;
                end
            end

            // Address is held three cycles to cover the two-cycle BRAM read latency.
            ST_RD: begin
                if (cnt == 2'd2) begin
                    cnt_d   = '0;
                    word_d  = (f_addra_q == LAST_ADDR) ? (mem.f_dina & LAST_WORD_MASK)
                                                       : mem.f_dina;
                    state_d = ST_SCAN;
                end else begin
                    cnt_d = cnt + 2'd1;
                end
            end

            ST_SCAN: begin
                if (!enc_valid) begin
`ifdef SPARSE_EXTRACT_CLEAR_EN
                    state_d = ST_CLR;
`else
                    state_d = ST_NEXT;
`endif
                end else if (weight_q == H_FULL) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    h_wea_d   = 1'b1;
                    h_addra_d = weight_q;
                    h_douta_d = {f_addra_q, enc_idx};
                    word_d    = word & (word - G_DAT_W'(1));
                    weight_d  = weight_q + H_ADDR_W'(1);
                end
            end

            ST_CLR: begin
                state_d = ST_NEXT;
            end

            ST_NEXT: begin
                if (f_addra_q == LAST_ADDR) begin
                    state_d = ST_FIN;
                end else begin
                    f_addra_d = f_addra_q + G_ADDR_W'(1);
                    cnt_d     = '0;
                    state_d   = ST_RD;
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_d = (state_d == ST_FIN);
    end

`ifdef SPARSE_EXTRACT_CLEAR_EN
    logic f_wea_q;

    // The clear write is registered so it lands during the CLR cycle with f_addra unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_wea_q <= 1'b0;
        end else begin
            f_wea_q <= (state_d == ST_CLR);
        end
    end

    assign mem.f_wea = f_wea_q;
`else
    assign mem.f_wea = 1'b0;
`endif

    assign mem.f_douta = '0;
    assign mem.f_addra = f_addra_q;
    assign mem.h_addra = h_addra_q;
    assign mem.h_douta = h_douta_q;
    assign mem.h_wea   = h_wea_q;
    assign done        = done_q;
    assign err         = err_q;
    assign weight      = weight_q;
    assign fsm_state   = state;

endmodule

// File: tb/tb_sparse_extract_ctrl.sv
// Randomized scoreboard bench for sparse_extract_ctrl with f/h BRAM models and a position-level model.
// Build with +define+SPARSE_EXTRACT_CLEAR_EN to exercise the f-clearing variant.
module tb_sparse_extract_ctrl;
    import keygen_pkg::*;

    localparam int XW        = H_ADDR_W + H_DAT_W;
    localparam int RUN_LIMIT = 1500;
`ifdef SPARSE_EXTRACT_CLEAR_EN
    localparam int WORD_CYCLES = 6;
    localparam bit CLEAR       = 1'b1;
`else
    localparam int WORD_CYCLES = 5;
    localparam bit CLEAR       = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic load_req = 1'b0;
    logic done, err;
    logic [H_ADDR_W-1:0] weight;
    state_t fsm_state;

    sparse_extract_ctrl_if mem_if ();

    logic [G_DAT_W-1:0] f_init [G_DAT_DEP];
    logic [G_DAT_W-1:0] f_mem  [G_DAT_DEP];
    logic [G_DAT_W-1:0] rd_p1, rd_p2;

    logic [XW-1:0] exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  exp_weight;
    bit  exp_err;
    int  err_word;

    sparse_extract_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .done      (done),
        .err       (err),
        .weight    (weight),
        .fsm_state (fsm_state),
        .mem       (mem_if)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- f BRAM model: 2-cycle read latency ----------------
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < G_DAT_DEP; i++) f_mem[i] <= f_init[i];
        end else if (mem_if.f_wea) begin
            f_mem[mem_if.f_addra] <= mem_if.f_douta;
        end
        rd_p1 <= f_mem[mem_if.f_addra];
        rd_p2 <= rd_p1;
    end
    assign mem_if.f_dina = rd_p2;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor: every h write must match the head of the queue ----------------
    always @(negedge clk) begin
        logic [XW-1:0] e;
        if (!rst && mem_if.h_wea) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL h_write: unexpected write addr=%0d data=%0d",
                         mem_if.h_addra, mem_if.h_douta);
            end else begin
                e = exp_q.pop_front();
                if ({mem_if.h_addra, mem_if.h_douta} !== e) begin
                    errors++;
                    $display("FAIL h_write: got addr=%0d data=%0d expected addr=%0d data=%0d",
                             mem_if.h_addra, mem_if.h_douta,
                             e[XW-1:H_DAT_W], e[H_DAT_W-1:0]);
                end
            end
        end
    end

    // ---------------- stimulus / reference model ----------------
    task automatic clear_f();
        for (int i = 0; i < G_DAT_DEP; i++) f_init[i] = '0;
    endtask

    task automatic set_bit(input int p);
        f_init[p / G_DAT_W][p % G_DAT_W] = 1'b1;
    endtask

    task automatic load_f();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // Walk polynomial positions 0..r-1 in order; the list caps at h capacity.
    task automatic build_expect();
        exp_q.delete();
        exp_weight = 0;
        exp_err    = 1'b0;
        err_word   = G_DAT_DEP;
        for (int p = 0; p < R; p++) begin
            if (f_init[p / G_DAT_W][p % G_DAT_W]) begin
                if (exp_weight == H_DAT_DEP) begin
                    exp_err  = 1'b1;
                    err_word = p / G_DAT_W;
                    break;
                end
                exp_q.push_back({H_ADDR_W'(exp_weight), H_DAT_W'(p)});
                exp_weight++;
            end
        end
    endtask

    task automatic run_and_check(input string name, input int exp_cycles, input int poke_at);
        int n;
        bit seen;
        int bad;
        logic [G_DAT_W-1:0] ew;
        build_expect();
        load_f();
        @(negedge clk);
        start = 1'b1;
        n     = 1;
        seen  = 1'b0;
        while (!seen && n < RUN_LIMIT) begin
            @(negedge clk);
            n++;
            start = (n == poke_at);
            if (n == 2) begin
                check({name, " err_cleared"}, err, 0);
                check({name, " weight_cleared"}, weight, 0);
            end
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check({name, " done_seen"}, seen, 1);
        if (exp_cycles != 0) check({name, " cycles"}, n, exp_cycles);
        check({name, " weight"}, weight, exp_weight);
        check({name, " err"}, err, exp_err);
        check({name, " pending_writes"}, exp_q.size(), 0);
        @(negedge clk);
        check({name, " done_one_cycle"}, done, 0);
        repeat (4) @(negedge clk);
        check({name, " weight_held"}, weight, exp_weight);
        check({name, " err_held"}, err, exp_err);
        bad = 0;
        for (int i = 0; i < G_DAT_DEP; i++) begin
            ew = (CLEAR && i < err_word) ? '0 : f_init[i];
            if (f_mem[i] !== ew) bad++;
        end
        check({name, " f_contents"}, bad, 0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " ctrl"}, {done, err, mem_if.f_wea, mem_if.h_wea}, 0);
        check({name, " weight"}, weight, 0);
        check({name, " f_addra"}, mem_if.f_addra, 0);
        check({name, " f_douta"}, mem_if.f_douta, 0);
        check({name, " h_addra"}, mem_if.h_addra, 0);
        check({name, " h_douta"}, mem_if.h_douta, 0);
        check({name, " state"}, fsm_state, ST_IDLE);
    endtask

    initial begin
        int n;
        bit reached;
        int cnt;

        clear_f();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // all-zero polynomial, with the full-scan latency
        clear_f();
        run_and_check("zero", G_DAT_DEP * WORD_CYCLES + 2, 0);

        clear_f();
        set_bit(100);
        run_and_check("single_100", 0, 0);

        clear_f();
        set_bit(0); set_bit(63); set_bit(64); set_bit(R - 1);
        run_and_check("edges", 0, 0);

        // padding bits only in the last word
        clear_f();
        f_init[G_DAT_DEP - 1] = 64'hFFF8_0000_0000_0000;
        run_and_check("padding", 0, 0);

        // 68 distinct positions: overflow
        clear_f();
        for (int i = 0; i < 68; i++) set_bit(i * 149);
        run_and_check("overflow", 0, 0);

        // reset during the scan of word 10
        clear_f();
        for (int w = 0; w < 21; w++) set_bit(w * G_DAT_W + int'($urandom_range(0, 63)));
        set_bit(10 * G_DAT_W + 5);
        set_bit(10 * G_DAT_W + 40);
        build_expect();
        load_f();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        n       = 0;
        reached = 1'b0;
        while (!reached && n < RUN_LIMIT) begin
            if (fsm_state == ST_SCAN && mem_if.f_addra == G_ADDR_W'(10)) reached = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check("mid_reset reached_word10", reached, 1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_and_check("after_reset", 0, 0);

        // randomized contents; one run also pokes start while busy
        for (int t = 0; t < 6; t++) begin
            clear_f();
            cnt = (t < 2) ? int'($urandom_range(60, 75)) : int'($urandom_range(0, 40));
            for (int k = 0; k < cnt; k++) set_bit(int'($urandom_range(0, R - 1)));
            for (int b = LAST_WORD_BITS; b < G_DAT_W; b++)
                f_init[G_DAT_DEP - 1][b] = 1'($urandom_range(0, 1));
            run_and_check($sformatf("random%0d", t), 0, (t == 3) ? 150 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
